// File: rtl/hilo_mdu_controller_pkg.sv
// rtl/hilo_mdu_controller_pkg.sv - shared MDU op codes, FSM states and widths
// Purpose: constants and types shared by the HI/LO controller and its divider core.
// Ports: none (package).

package hilo_mdu_controller_pkg;

    localparam int DATA_WIDTH = 32;

    localparam logic ENABLE  = 1'b1;
    localparam logic DISABLE = 1'b0;

    localparam logic [2:0] MDU_OP_NOP   = 3'd0;
    localparam logic [2:0] MDU_OP_MULT  = 3'd1;
    localparam logic [2:0] MDU_OP_MULTU = 3'd2;
    localparam logic [2:0] MDU_OP_DIV   = 3'd3;
    localparam logic [2:0] MDU_OP_DIVU  = 3'd4;
    localparam logic [2:0] MDU_OP_MTHI  = 3'd5;
    localparam logic [2:0] MDU_OP_MTLO  = 3'd6;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_DIV_RUN = 2'd1,
        ST_DIV_FIX = 2'd2,
        ST_DONE    = 2'd3
    } mdu_state_e;

endpackage

// File: rtl/hilo_mdu_controller_div_core.sv
// rtl/hilo_mdu_controller_div_core.sv - unsigned restoring divider iterator
// Purpose: one quotient bit per step; W steps after start give quo/rem of dividend/divisor.
// Ports:
//   clock, reset        clock and asynchronous active-high reset
//   start               load dividend/divisor, clear remainder and step count
//   step                perform one restoring iteration
//   dividend, divisor   unsigned operands, sampled on start
//   done                high during the final step (combinational)
//   quo, rem            running quotient / remainder; final after the last step

module hilo_div_core
    import hilo_mdu_controller_pkg::*;
#(
    parameter int W = DATA_WIDTH
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         start,
    input  logic         step,
    input  logic [W-1:0] dividend,
    input  logic [W-1:0] divisor,
    output logic         done,
    output logic [W-1:0] quo,
    output logic [W-1:0] rem
);

    localparam int CW = $clog2(W);

    logic [W-1:0]  quo_q, quo_d;
    logic [W-1:0]  rem_q, rem_d;
    logic [W-1:0]  dsr_q, dsr_d;
    logic [CW-1:0] count_q, count_d;

    logic [W:0] shifted;
    logic [W:0] trial;

    // Shift the next dividend bit into the partial remainder and try the subtract;
    // a borrow (trial[W]) means the divisor did not fit and the remainder is restored.
    assign shifted = {rem_q, quo_q[W-1]};
    assign trial   = shifted - {1'b0, dsr_q};
    assign done    = step && (count_q == CW'(W - 1));
    assign quo     = quo_q;
    assign rem     = rem_q;

    always_comb begin
        quo_d   = quo_q;
        rem_d   = rem_q;
        dsr_d   = dsr_q;
        count_d = count_q;
        if (start) begin
            quo_d   = dividend;
            rem_d   = '0;
            dsr_d   = divisor;
            count_d = '0;
        end else if (step) begin
            quo_d   = {quo_q[W-2:0], ~trial[W]};
            rem_d   = trial[W] ? shifted[W-1:0] : trial[W-1:0];
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            quo_q   <= '0;
            rem_q   <= '0;
            dsr_q   <= '0;
            count_q <= '0;
        end else begin
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            dsr_q   <= dsr_d;
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/hilo_mdu_controller.sv
// rtl/hilo_mdu_controller.sv - HI/LO write sequencer for MULT/DIV/MTHI/MTLO
// Purpose: accepts HI/LO-class ops in EX, runs the multiplier or divider, stalls the
//   pipeline until the result is ready and drives the hilo_file write port once per op.
// Ports:
//   clock, reset                 clock and asynchronous active-high reset
//   op_valid, op_code            HI/LO instruction present in EX and its MDU_OP_* code
//   operand_a, operand_b         rs / rt values, latched on accept
//   cancel                       pipeline flush, aborts any op with no write
//   hi_in, lo_in                 current HI/LO, the half kept by MTLO/MTHI
//   stall                        hold EX and earlier stages
//   write_hilo_enable            hilo_file write strobe
//   write_hi_data, write_lo_data hilo_file write data
//   busy                         controller not idle

module hilo_mdu_controller
    import hilo_mdu_controller_pkg::*;
#(
    parameter int W = DATA_WIDTH
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         op_valid,
    input  logic [2:0]   op_code,
    input  logic [W-1:0] operand_a,
    input  logic [W-1:0] operand_b,
    input  logic         cancel,
    input  logic [W-1:0] hi_in,
    input  logic [W-1:0] lo_in,
    output logic         stall,
    output logic         write_hilo_enable,
    output logic [W-1:0] write_hi_data,
    output logic [W-1:0] write_lo_data,
    output logic         busy
);

    mdu_state_e state_q, state_d;
    logic [W-1:0] hi_q, hi_d;
    logic [W-1:0] lo_q, lo_d;
    logic         quo_neg_q, quo_neg_d;
    logic         rem_neg_q, rem_neg_d;

    logic         div_start;
    logic         div_step;
    logic         div_done;
    logic [W-1:0] div_quo;
    logic [W-1:0] div_rem;

    logic         is_signed;
    logic [W-1:0] a_mag;
    logic [W-1:0] b_mag;
    logic [2*W-1:0] a_ext;
    logic [2*W-1:0] b_ext;
    logic [2*W-1:0] product;

    // Both signed ops (MULT, DIV) take the signed path; everything else is unsigned.
    assign is_signed = (op_code == MDU_OP_MULT) || (op_code == MDU_OP_DIV);

    // Sign-extending to 2W bits and keeping the low 2W bits of the product yields the
    // correct two's-complement result for the signed case as well.
    assign a_ext   = {{W{is_signed & operand_a[W-1]}}, operand_a};
    assign b_ext   = {{W{is_signed & operand_b[W-1]}}, operand_b};
    assign product = a_ext * b_ext;

    // Magnitudes for the unsigned divider; -0x80000000 wraps to itself, which is the
    // correct unsigned magnitude.
    assign a_mag = (is_signed && operand_a[W-1]) ? (~operand_a + 1'b1) : operand_a;
    assign b_mag = (is_signed && operand_b[W-1]) ? (~operand_b + 1'b1) : operand_b;

    hilo_div_core #(.W(W)) u_div_core (
        .clock    (clock),
        .reset    (reset),
        .start    (div_start),
        .step     (div_step),
        .dividend (a_mag),
        .divisor  (b_mag),
        .done     (div_done),
        .quo      (div_quo),
        .rem      (div_rem)
    );

    always_comb begin
        state_d           = state_q;
        hi_d              = hi_q;
        lo_d              = lo_q;
        quo_neg_d         = quo_neg_q;
        rem_neg_d         = rem_neg_q;
        stall             = DISABLE;
        write_hilo_enable = DISABLE;
        write_hi_data     = '0;
        write_lo_data     = '0;
        div_start         = DISABLE;
        div_step          = DISABLE;

        unique case (state_q)
            ST_IDLE: begin
                if (op_valid && !cancel) begin
                    case (op_code)
                        MDU_OP_MTHI: begin
                            write_hilo_enable = ENABLE;
                            write_hi_data     = operand_a;
                            write_lo_data     = lo_in;
                        end
                        MDU_OP_MTLO: begin
                            write_hilo_enable = ENABLE;
                            write_hi_data     = hi_in;
                            write_lo_data     = operand_a;
                        end
                        MDU_OP_MULT, MDU_OP_MULTU: begin
                            stall   = ENABLE;
                            hi_d    = product[2*W-1:W];
                            lo_d    = product[W-1:0];
                            state_d = ST_DONE;
                        end
                        MDU_OP_DIV, MDU_OP_DIVU: begin
                            stall = ENABLE;
                            if (operand_b == '0) begin
                                hi_d    = operand_a;
                                lo_d    = '1;
                                state_d = ST_DONE;
                            end else begin
                                div_start = ENABLE;
                                quo_neg_d = is_signed & (operand_a[W-1] ^ operand_b[W-1]);
                                rem_neg_d = is_signed & operand_a[W-1];
                                state_d   = ST_DIV_RUN;
                            end
                        end
                        default: ;
                    endcase
                end
            end
            ST_DIV_RUN: begin
                stall    = ENABLE;
                div_step = ENABLE;
                if (div_done) begin
                    state_d = ST_DIV_FIX;
                end
            end
            ST_DIV_FIX: begin
                stall   = ENABLE;
                lo_d    = quo_neg_q ? (~div_quo + 1'b1) : div_quo;
                hi_d    = rem_neg_q ? (~div_rem + 1'b1) : div_rem;
                state_d = ST_DONE;
            end
            ST_DONE: begin
                // The finished instruction is still in EX, so op_valid is not re-sampled here.
                write_hilo_enable = ENABLE;
                write_hi_data     = hi_q;
                write_lo_data     = lo_q;
                state_d           = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // A flush wins over everything in the same cycle.
        if (cancel) begin
            state_d           = ST_IDLE;
            stall             = DISABLE;
            write_hilo_enable = DISABLE;
            write_hi_data     = '0;
            write_lo_data     = '0;
            div_start         = DISABLE;
            div_step          = DISABLE;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            hi_q      <= '0;
            lo_q      <= '0;
            quo_neg_q <= 1'b0;
            rem_neg_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            quo_neg_q <= quo_neg_d;
            rem_neg_q <= rem_neg_d;
        end
    end

    assign busy = (state_q != ST_IDLE);

endmodule

// File: tb/tb_hilo_mdu_controller.sv
// tb/tb_hilo_mdu_controller.sv - self-checking bench for hilo_mdu_controller

module tb_hilo_mdu_controller;
    import hilo_mdu_controller_pkg::*;

    logic        clock = 1'b0;
    logic        reset;
    logic        op_valid;
    logic [2:0]  op_code;
    logic [31:0] operand_a;
    logic [31:0] operand_b;
    logic        cancel;
    logic [31:0] hi_in;
    logic [31:0] lo_in;
    logic        stall;
    logic        write_hilo_enable;
    logic [31:0] write_hi_data;
    logic [31:0] write_lo_data;
    logic        busy;

    int total = 0;
    int bad   = 0;
    logic [63:0] exp_q[$];

    hilo_mdu_controller dut (
        .clock             (clock),
        .reset             (reset),
        .op_valid          (op_valid),
        .op_code           (op_code),
        .operand_a         (operand_a),
        .operand_b         (operand_b),
        .cancel            (cancel),
        .hi_in             (hi_in),
        .lo_in             (lo_in),
        .stall             (stall),
        .write_hilo_enable (write_hilo_enable),
        .write_hi_data     (write_hi_data),
        .write_lo_data     (write_lo_data),
        .busy              (busy)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drives one op, waits for its write, and checks data, write latency and stall length.
    task automatic run_op(input string tag, input logic [2:0] code, input logic [31:0] a,
                          input logic [31:0] b, input logic [63:0] exp, input int exp_lat,
                          input bit scramble);
        int lat;
        int stall_cnt;
        logic [63:0] want;
        lat       = -1;
        stall_cnt = 0;
        exp_q.push_back(exp);
        op_code   = code;
        operand_a = a;
        operand_b = b;
        op_valid  = 1'b1;
        for (int k = 0; k < 60; k++) begin
            @(negedge clock);
            if (write_hilo_enable) begin
                chk({tag, "_stall_at_write"}, 64'(stall), 64'(0));
                if (exp_q.size() == 0) begin
                    chk({tag, "_unexpected_write"}, 64'(1), 64'(0));
                end else begin
                    want = exp_q.pop_front();
                    chk({tag, "_hilo"}, {write_hi_data, write_lo_data}, want);
                end
                lat = k;
                break;
            end
            if (stall) stall_cnt++;
            @(posedge clock);
            #1;
            if (scramble && k == 3) begin
                op_code   = MDU_OP_MULT;
                operand_a = $urandom;
                operand_b = $urandom;
            end
        end
        if (lat < 0 && exp_q.size() != 0) void'(exp_q.pop_back());
        chk({tag, "_latency"}, 64'(lat), 64'(exp_lat));
        chk({tag, "_stall_cycles"}, 64'(stall_cnt), 64'(exp_lat));
        @(posedge clock);
        #1;
        op_valid = 1'b0;
        op_code  = MDU_OP_NOP;
    endtask

    initial begin : main
        logic [31:0] ra, rb;
        int          sa, sbv;
        longint      pa, pb;
        int          writes;

        reset     = 1'b1;
        op_valid  = 1'b0;
        op_code   = MDU_OP_NOP;
        operand_a = '0;
        operand_b = '0;
        cancel    = 1'b0;
        hi_in     = 32'h5555_5555;
        lo_in     = 32'hAAAA_0000;

        repeat (2) @(posedge clock);
        @(negedge clock);
        chk("reset_busy", 64'(busy), 64'(0));
        chk("reset_stall", 64'(stall), 64'(0));
        chk("reset_we", 64'(write_hilo_enable), 64'(0));
        chk("reset_data", {write_hi_data, write_lo_data}, 64'(0));
        @(posedge clock);
        #1;
        reset = 1'b0;

        // NOP with op_valid: nothing happens.
        op_valid = 1'b1;
        op_code  = MDU_OP_NOP;
        writes   = 0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clock);
            if (write_hilo_enable || stall || busy) writes++;
            @(posedge clock);
            #1;
        end
        op_valid = 1'b0;
        chk("nop_no_action", 64'(writes), 64'(0));

        run_op("mthi", MDU_OP_MTHI, 32'h1234_5678, 32'h0, {32'h1234_5678, 32'hAAAA_0000}, 0, 1'b0);
        run_op("mtlo", MDU_OP_MTLO, 32'hDEAD_BEEF, 32'h0, {32'h5555_5555, 32'hDEAD_BEEF}, 0, 1'b0);
        run_op("mult", MDU_OP_MULT, 32'hFFFF_FFFE, 32'd3, {32'hFFFF_FFFF, 32'hFFFF_FFFA}, 1, 1'b0);
        run_op("multu", MDU_OP_MULTU, 32'hFFFF_FFFE, 32'd3, {32'h0000_0002, 32'hFFFF_FFFA}, 1, 1'b0);
        run_op("div_neg7_2", MDU_OP_DIV, 32'hFFFF_FFF9, 32'd2, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 34, 1'b0);
        run_op("divu_100_7", MDU_OP_DIVU, 32'd100, 32'd7, {32'd2, 32'd14}, 34, 1'b1);
        run_op("div_by_zero", MDU_OP_DIV, 32'h0000_1234, 32'd0, {32'h0000_1234, 32'hFFFF_FFFF}, 1, 1'b0);
        run_op("div_min_neg1", MDU_OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, {32'h0, 32'h8000_0000}, 34, 1'b0);

        for (int i = 0; i < 2; i++) begin
            ra = $urandom;
            rb = $urandom;
            pa = longint'($signed(ra));
            pb = longint'($signed(rb));
            run_op("rand_mult", MDU_OP_MULT, ra, rb, 64'(pa * pb), 1, 1'b0);
            run_op("rand_multu", MDU_OP_MULTU, ra, rb, {32'h0, ra} * {32'h0, rb}, 1, 1'b0);
        end
        for (int i = 0; i < 3; i++) begin
            ra = $urandom;
            rb = 32'($urandom_range(1, 1000));
            run_op("rand_divu", MDU_OP_DIVU, ra, rb, {ra % rb, ra / rb}, 34, 1'b0);
            ra = $urandom;
            rb = $urandom;
            if (rb == 32'h0) rb = 32'd5;
            if (ra == 32'h8000_0000) ra = 32'h8000_0001;
            sa  = $signed(ra);
            sbv = $signed(rb);
            run_op("rand_div", MDU_OP_DIV, ra, rb, {32'(sa % sbv), 32'(sa / sbv)}, 34, 1'b0);
        end

        // Cancel at T+10 of a DIV: no write, ever.
        op_code   = MDU_OP_DIV;
        operand_a = 32'd100;
        operand_b = 32'd3;
        op_valid  = 1'b1;
        writes    = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clock);
            if (write_hilo_enable) writes++;
            @(posedge clock);
            #1;
        end
        cancel = 1'b1;
        @(negedge clock);
        chk("cancel_stall", 64'(stall), 64'(0));
        chk("cancel_we", 64'(write_hilo_enable), 64'(0));
        @(posedge clock);
        #1;
        cancel   = 1'b0;
        op_valid = 1'b0;
        @(negedge clock);
        chk("cancel_idle", 64'(busy), 64'(0));
        for (int k = 0; k < 45; k++) begin
            @(negedge clock);
            if (write_hilo_enable) writes++;
        end
        chk("cancel_no_write", 64'(writes), 64'(0));

        // Asynchronous reset in the middle of DIV_RUN.
        @(posedge clock);
        #1;
        op_code   = MDU_OP_DIVU;
        operand_a = 32'd1000;
        operand_b = 32'd9;
        op_valid  = 1'b1;
        repeat (5) @(posedge clock);
        #1;
        op_valid = 1'b0;
        @(negedge clock);
        chk("pre_reset_busy", 64'(busy), 64'(1));
        #2;
        reset = 1'b1;
        #1;
        chk("async_reset_busy", 64'(busy), 64'(0));
        chk("async_reset_stall", 64'(stall), 64'(0));
        chk("async_reset_we", 64'(write_hilo_enable), 64'(0));
        chk("async_reset_data", {write_hi_data, write_lo_data}, 64'(0));
        @(posedge clock);
        #1;
        reset = 1'b0;

        run_op("post_reset_divu", MDU_OP_DIVU, 32'd1000, 32'd9, {32'd1, 32'd111}, 34, 1'b0);

        chk("scoreboard_empty", 64'(exp_q.size()), 64'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
